dataq_demux_out: RTL and testbench

- Return-path companion to the input data Q-mux: collects 4-bit lane results A/B/C/D and drives them out through the UIO output pins, or feeds them back into the M/N operand registers.
- Command opcode R mirrors the Q encoding: bits [3:2] select the destination, bits [1:0] select the lane pairing.
- Multi-beat transfers go through a small FSM; UIO transfers use a valid/ready handshake.

---
 rtl/dataq_pkg.sv | 40 ++++
 rtl/dataq_beat_sel.sv | 53 +++++
 rtl/dataq_demux_out.sv | 226 ++++++++++++++++++++++
 tb/tb_dataq_demux_out.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dataq_pkg.sv
// Shared definitions for the data Q-mux return path: opcode fields,
// destination/pairing codes and the beat FSM encoding.
package dataq_pkg;

  localparam int WIDTH_DEF = 4;

  // Opcode field positions inside R
  localparam int R_DST_MSB = 3;
  localparam int R_DST_LSB = 2;
  localparam int R_SEL_MSB = 1;
  localparam int R_SEL_LSB = 0;

  // Destination codes, R[3:2]
  localparam logic [1:0] DST_ZERO = 2'b00;
  localparam logic [1:0] DST_UIO  = 2'b01;
  localparam logic [1:0] DST_MN   = 2'b10;
  localparam logic [1:0] DST_RSV  = 2'b11;

  // Lane pairing codes, R[1:0]
  localparam logic [1:0] SEL_ACBD = 2'b00;
  localparam logic [1:0] SEL_CD   = 2'b01;
  localparam logic [1:0] SEL_AB   = 2'b10;
  localparam logic [1:0] SEL_ABCD = 2'b11;

  // Beat FSM encoding, shared with the input Q-mux decode
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT1 = 2'b01,
    ST_BEAT2 = 2'b10
  } state_t;

  function automatic logic [1:0] r_dst(input logic [3:0] r);
    return r[R_DST_MSB:R_DST_LSB];
  endfunction

  function automatic logic [1:0] r_sel(input logic [3:0] r);
    return r[R_SEL_MSB:R_SEL_LSB];
  endfunction

endpackage

// File: rtl/dataq_beat_sel.sv
// Beat selector: maps the four lanes onto the {high, low} nibbles of one
// beat for a given pairing and beat index, and flags the final beat.
module dataq_beat_sel
  import dataq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] lane_a,
  input  logic [WIDTH-1:0] lane_b,
  input  logic [WIDTH-1:0] lane_c,
  input  logic [WIDTH-1:0] lane_d,
  input  logic [1:0]       sel,
  input  logic             beat,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last_beat
);

  // Single-beat pairings ignore the beat index and always report last.
  always_comb begin
    hi        = lane_a;
    lo        = lane_b;
    last_beat = 1'b1;
    case (sel)
      SEL_CD: begin
        hi        = lane_c;
        lo        = lane_d;
        last_beat = 1'b1;
      end
      SEL_AB: begin
        hi        = lane_a;
        lo        = lane_b;
        last_beat = 1'b1;
      end
      SEL_ABCD: begin
        hi        = beat ? lane_c : lane_a;
        lo        = beat ? lane_d : lane_b;
        last_beat = beat;
      end
      SEL_ACBD: begin
        hi        = beat ? lane_b : lane_a;
        lo        = beat ? lane_d : lane_c;
        last_beat = beat;
      end
      default: begin
        hi        = lane_a;
        lo        = lane_b;
        last_beat = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dataq_demux_out.sv
// Return-path data demux: takes the A..D lane results and sends them out
// over the UIO pins (valid/ready) or back into the M/N operand registers.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for start; zero/NOP/reserved commands finish here
//   ST_BEAT1 | first beat presented on UIO or written to M/N
//   ST_BEAT2 | second beat of a two-beat pairing presented/written
module dataq_demux_out
  import dataq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         R,
  input  logic               start,
  input  logic [WIDTH-1:0]   fromA,
  input  logic [WIDTH-1:0]   fromB,
  input  logic [WIDTH-1:0]   fromC,
  input  logic [WIDTH-1:0]   fromD,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   UIOh_out,
  output logic [WIDTH-1:0]   UIOl_out,
  output logic [2*WIDTH-1:0] uio_oe,
  output logic               out_valid,
  output logic [WIDTH-1:0]   M_out,
  output logic [WIDTH-1:0]   N_out,
  output logic               mn_we,
  output logic               busy,
  output logic               cmd_err
);

  state_t state, state_nxt;

  logic [WIDTH-1:0] snap_a, snap_b, snap_c, snap_d;
  logic [1:0]       dst_q, sel_q;
  logic             last_q, last_nxt;

  logic [WIDTH-1:0]   uioh_q, uiol_q, uioh_nxt, uiol_nxt;
  logic               valid_q, valid_nxt;
  logic [2*WIDTH-1:0] oe_q;
  logic [WIDTH-1:0]   m_q, n_q, m_nxt, n_nxt;
  logic               we_q, we_nxt;
  logic               busy_q;
  logic               err_q, err_nxt;

  logic       accept;
  logic [1:0] r_d, r_s;
  logic       use_live;

  logic [WIDTH-1:0] bs_a, bs_b, bs_c, bs_d, bs_hi, bs_lo;
  logic [1:0]       bs_sel;
  logic             bs_beat, bs_last;

  assign accept = start && (state == ST_IDLE);
  assign r_d    = r_dst(R);
  assign r_s    = r_sel(R);

  // The first beat must be registered at the accept edge, before the
  // snapshot exists, so it is selected from the live lanes; the second
  // beat always comes from the snapshot.
  assign use_live = (state == ST_IDLE);
  assign bs_a     = use_live ? fromA : snap_a;
  assign bs_b     = use_live ? fromB : snap_b;
  assign bs_c     = use_live ? fromC : snap_c;
  assign bs_d     = use_live ? fromD : snap_d;
  assign bs_sel   = use_live ? r_s   : sel_q;
  assign bs_beat  = ~use_live;

  dataq_beat_sel #(.WIDTH(WIDTH)) u_beat_sel (
    .lane_a    (bs_a),
    .lane_b    (bs_b),
    .lane_c    (bs_c),
    .lane_d    (bs_d),
    .sel       (bs_sel),
    .beat      (bs_beat),
    .hi        (bs_hi),
    .lo        (bs_lo),
    .last_beat (bs_last)
  );

  // State, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      snap_a <= '0;
      snap_b <= '0;
      snap_c <= '0;
      snap_d <= '0;
      dst_q  <= DST_ZERO;
      sel_q  <= SEL_ACBD;
      last_q <= 1'b0;
      uioh_q <= '0;
      uiol_q <= '0;
      valid_q <= 1'b0;
      oe_q   <= '0;
      m_q    <= '0;
      n_q    <= '0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        snap_a <= fromA;
        snap_b <= fromB;
        snap_c <= fromC;
        snap_d <= fromD;
        dst_q  <= r_d;
        sel_q  <= r_s;
      end
      last_q  <= last_nxt;
      uioh_q  <= uioh_nxt;
      uiol_q  <= uiol_nxt;
      valid_q <= valid_nxt;
      oe_q    <= {(2*WIDTH){valid_nxt}};
      m_q     <= m_nxt;
      n_q     <= n_nxt;
      we_q    <= we_nxt;
      busy_q  <= (state_nxt != ST_IDLE);
      err_q   <= err_nxt;
    end
  end

  // Next state: UIO beats advance only on a handshake, MN beats every cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && (r_d == DST_UIO || r_d == DST_MN))
          state_nxt = ST_BEAT1;
      end
      ST_BEAT1: begin
        if (dst_q != DST_UIO || out_ready)
          state_nxt = last_q ? ST_IDLE : ST_BEAT2;
      end
      ST_BEAT2: begin
        if (dst_q != DST_UIO || out_ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next output values; everything holds unless a beat loads or retires.
  always_comb begin
    uioh_nxt  = uioh_q;
    uiol_nxt  = uiol_q;
    valid_nxt = valid_q;
    m_nxt     = m_q;
    n_nxt     = n_q;
    we_nxt    = 1'b0;
    err_nxt   = 1'b0;
    last_nxt  = last_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (r_d)
            DST_ZERO: begin
              if (r_s != 2'b00) begin
                m_nxt  = '0;
                n_nxt  = '0;
                we_nxt = 1'b1;
              end
            end
            DST_UIO: begin
              uioh_nxt  = bs_hi;
              uiol_nxt  = bs_lo;
              valid_nxt = 1'b1;
              last_nxt  = bs_last;
            end
            DST_MN: begin
              m_nxt    = bs_hi;
              n_nxt    = bs_lo;
              we_nxt   = 1'b1;
              last_nxt = bs_last;
            end
            default: err_nxt = 1'b1;
          endcase
        end
      end
      ST_BEAT1: begin
        if (dst_q == DST_UIO) begin
          if (out_ready) begin
            if (last_q) begin
              uioh_nxt  = '0;
              uiol_nxt  = '0;
              valid_nxt = 1'b0;
            end else begin
              uioh_nxt = bs_hi;
              uiol_nxt = bs_lo;
              last_nxt = bs_last;
            end
          end
        end else if (!last_q) begin
          m_nxt    = bs_hi;
          n_nxt    = bs_lo;
          we_nxt   = 1'b1;
          last_nxt = bs_last;
        end
      end
      ST_BEAT2: begin
        if (dst_q == DST_UIO && out_ready) begin
          uioh_nxt  = '0;
          uiol_nxt  = '0;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign UIOh_out  = uioh_q;
  assign UIOl_out  = uiol_q;
  assign out_valid = valid_q;
  assign uio_oe    = oe_q;
  assign M_out     = m_q;
  assign N_out     = n_q;
  assign mn_we     = we_q;
  assign busy      = busy_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_dataq_demux_out.sv
// Bench for dataq_demux_out: directed scenarios plus random commands,
// checked against a beat-list reference model.
module tb_dataq_demux_out;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     R;
  logic           start;
  logic [W-1:0]   fromA, fromB, fromC, fromD;
  logic           out_ready;
  logic [W-1:0]   UIOh_out, UIOl_out;
  logic [2*W-1:0] uio_oe;
  logic           out_valid;
  logic [W-1:0]   M_out, N_out;
  logic           mn_we;
  logic           busy;
  logic           cmd_err;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] exp_m = 4'd0;
  logic [3:0] exp_n = 4'd0;

  dataq_demux_out #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .R         (R),
    .start     (start),
    .fromA     (fromA),
    .fromB     (fromB),
    .fromC     (fromC),
    .fromD     (fromD),
    .out_ready (out_ready),
    .UIOh_out  (UIOh_out),
    .UIOl_out  (UIOl_out),
    .uio_oe    (uio_oe),
    .out_valid (out_valid),
    .M_out     (M_out),
    .N_out     (N_out),
    .mn_we     (mn_we),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_mn(input string tag);
    chk({tag, "_m"}, 8'(M_out), 8'(exp_m));
    chk({tag, "_n"}, 8'(N_out), 8'(exp_n));
  endtask

  // Issues one command and follows it to completion. The expected beat list
  // comes straight from the pairing rules; stray starts during a transfer
  // must be ignored.
  task automatic run_cmd(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d, input int pct,
                         input int stall, input bit mutate, input bit stray);
    logic [7:0] bq[$];
    int cyc;
    bit rdy;
    case (r[1:0])
      2'b01: bq.push_back({c, d});
      2'b10: bq.push_back({a, b});
      2'b11: begin bq.push_back({a, b}); bq.push_back({c, d}); end
      default: begin bq.push_back({a, c}); bq.push_back({b, d}); end
    endcase
    R = r; fromA = a; fromB = b; fromC = c; fromD = d;
    start = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    tick;
    start = 1'b0;
    if (mutate) begin
      fromA = 4'($urandom); fromB = 4'($urandom);
      fromC = 4'($urandom); fromD = 4'($urandom);
    end
    case (r[3:2])
      2'b00: begin
        if (r[1:0] != 2'b00) begin
          exp_m = 4'd0; exp_n = 4'd0;
          chk("zero_we", 8'(mn_we), 8'd1);
        end else begin
          chk("nop_we", 8'(mn_we), 8'd0);
        end
        chk_mn("zero");
        chk("zero_busy", 8'(busy), 8'd0);
        chk("zero_valid", 8'(out_valid), 8'd0);
        tick;
        chk("zero_we_clr", 8'(mn_we), 8'd0);
        chk_mn("zero_hold");
      end
      2'b11: begin
        chk("rsv_err", 8'(cmd_err), 8'd1);
        chk("rsv_busy", 8'(busy), 8'd0);
        chk("rsv_valid", 8'(out_valid), 8'd0);
        chk("rsv_we", 8'(mn_we), 8'd0);
        chk_mn("rsv");
        tick;
        chk("rsv_err_clr", 8'(cmd_err), 8'd0);
      end
      2'b01: begin
        cyc = 0;
        while (bq.size() > 0) begin
          if (cyc >= 400) begin
            chk("uio_timeout", 8'd1, 8'd0);
            break;
          end
          chk("uio_valid", 8'(out_valid), 8'd1);
          chk("uio_oe", uio_oe, 8'hFF);
          chk("uio_data", {UIOh_out, UIOl_out}, bq[0]);
          chk("uio_busy", 8'(busy), 8'd1);
          chk("uio_we", 8'(mn_we), 8'd0);
          rdy = (cyc < stall) ? 1'b0 : ($urandom_range(0, 99) < pct);
          out_ready = rdy;
          if (stray) begin
            start = ($urandom_range(0, 3) == 0);
            R = 4'($urandom);
          end
          tick;
          start = 1'b0;
          cyc++;
          if (rdy) void'(bq.pop_front());
        end
        chk("uio_end_valid", 8'(out_valid), 8'd0);
        chk("uio_end_oe", uio_oe, 8'h00);
        chk("uio_end_data", {UIOh_out, UIOl_out}, 8'h00);
        chk("uio_end_busy", 8'(busy), 8'd0);
        chk_mn("uio_mn_hold");
      end
      default: begin
        while (bq.size() > 0) begin
          chk("mn_m", 8'(M_out), 8'(bq[0][7:4]));
          chk("mn_n", 8'(N_out), 8'(bq[0][3:0]));
          chk("mn_we", 8'(mn_we), 8'd1);
          chk("mn_valid", 8'(out_valid), 8'd0);
          chk("mn_busy", 8'(busy), 8'd1);
          exp_m = bq[0][7:4];
          exp_n = bq[0][3:0];
          out_ready = 1'($urandom_range(0, 1));
          if (stray) begin
            start = ($urandom_range(0, 3) == 0);
            R = 4'($urandom);
          end
          tick;
          start = 1'b0;
          void'(bq.pop_front());
        end
        chk("mn_end_we", 8'(mn_we), 8'd0);
        chk("mn_end_busy", 8'(busy), 8'd0);
        chk("mn_end_valid", 8'(out_valid), 8'd0);
        chk_mn("mn_hold");
      end
    endcase
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 8'(out_valid), 8'd0);
    chk({tag, "_oe"}, uio_oe, 8'h00);
    chk({tag, "_uio"}, {UIOh_out, UIOl_out}, 8'h00);
    chk({tag, "_m"}, 8'(M_out), 8'd0);
    chk({tag, "_n"}, 8'(N_out), 8'd0);
    chk({tag, "_we"}, 8'(mn_we), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_err"}, 8'(cmd_err), 8'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; R = 4'd0; out_ready = 1'b0;
    fromA = 4'd0; fromB = 4'd0; fromC = 4'd0; fromD = 4'd0;
    tick;
    tick;
    chk_all_zero("reset");
    rst = 1'b0;

    // preload M/N = 5/3, zero them, then NOP
    run_cmd(4'b1001, 4'd0, 4'd0, 4'd5, 4'd3, 100, 0, 1'b0, 1'b0);
    run_cmd(4'b0011, 4'd0, 4'd0, 4'd0, 4'd0, 100, 0, 1'b0, 1'b0);
    run_cmd(4'b0000, 4'd1, 4'd2, 4'd3, 4'd4, 100, 0, 1'b0, 1'b0);

    // UIO two-beat with a 3-cycle stall on the first beat
    run_cmd(4'b0111, 4'd1, 4'd2, 4'd3, 4'd4, 100, 3, 1'b0, 1'b0);

    // split pairing, lanes change after accept, stray starts ignored
    run_cmd(4'b0100, 4'd9, 4'd8, 4'd7, 4'd6, 100, 0, 1'b1, 1'b1);

    // MN feedback, two beats
    run_cmd(4'b1011, 4'd1, 4'd2, 4'd3, 4'd4, 100, 0, 1'b0, 1'b0);

    // reserved opcode
    run_cmd(4'b1101, 4'd1, 4'd2, 4'd3, 4'd4, 100, 0, 1'b0, 1'b0);

    // reset while a UIO beat is stalled
    R = 4'b0101; fromA = 4'd1; fromB = 4'd2; fromC = 4'd3; fromD = 4'd4;
    start = 1'b1; out_ready = 1'b0;
    tick;
    start = 1'b0;
    chk("pre_rst_valid", 8'(out_valid), 8'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_m = 4'd0; exp_n = 4'd0;
    chk_all_zero("mid_rst");
    run_cmd(4'b0110, 4'd10, 4'd11, 4'd12, 4'd13, 100, 0, 1'b0, 1'b0);

    // random commands, back to back
    for (int i = 0; i < 150; i++) begin
      run_cmd(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
              $urandom_range(20, 100), 0, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
